hid_multi: RTL

Parametrised host-interface HID block between the IO MCU byte link and the C64 core. It decodes MCU command frames into:
- an 8x8 keyboard matrix;
- `NUM_JOY` digital joystick registers;
- a mouse with saturating per-axis accumulators and 2-bit gray quadrature outputs, drained at a programmable rate.

Next generation of the existing HID decoder. Adds: configurable joystick count and counter widths, saturation instead of wrap, a clear-keyboard command, and a capability-reporting status command.

---
 rtl/hid_multi_pkg.sv | 23 ++
 rtl/hid_multi_if.sv | 31 +++
 rtl/hid_multi_mouse_axis.sv | 66 ++++++
 rtl/hid_multi.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/hid_multi_pkg.sv
//------------------------------------------------------------------------------
// Module   : hid_pkg
// Purpose  : Shared command codes and status identifiers for the HID decoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hid_pkg;

  // Command byte values carried by a start-qualified strobe
  localparam logic [7:0] CMD_STATUS = 8'd0;
  localparam logic [7:0] CMD_KEY    = 8'd1;
  localparam logic [7:0] CMD_MOUSE  = 8'd2;
  localparam logic [7:0] CMD_JOY    = 8'd3;
  localparam logic [7:0] CMD_KBCLR  = 8'd4;

  // Fixed identification bytes returned by the status command
  localparam logic [7:0] STATUS_ID0 = 8'h5C;
  localparam logic [7:0] STATUS_ID1 = 8'h42;

endpackage

`default_nettype wire

// File: rtl/hid_multi_if.sv
//------------------------------------------------------------------------------
// Module   : hid_multi_if
// Purpose  : MCU byte link (strobe/start/data in, reply byte out).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hid_multi_if;
  logic       data_in_strobe;
  logic       data_in_start;
  logic [7:0] data_in;
  logic [7:0] data_out;

  // MCU side drives bytes and reads the reply
  modport master (
    output data_in_strobe,
    output data_in_start,
    output data_in,
    input  data_out
  );

  // HID decoder side consumes bytes and drives the reply
  modport slave (
    input  data_in_strobe,
    input  data_in_start,
    input  data_in,
    output data_out
  );
endinterface

`default_nettype wire

// File: rtl/hid_multi_mouse_axis.sv
//------------------------------------------------------------------------------
// Module   : hid_mouse_axis
// Purpose  : One mouse axis: saturating signed accumulator, drain toward zero
//            on tick, 2-bit gray quadrature output.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hid_mouse_axis #(
  parameter int MOUSE_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   wr,
  input  logic [7:0]             delta,
  output logic [MOUSE_CNT_W-1:0] cnt,
  output logic [1:0]             quad
);

  localparam int W = MOUSE_CNT_W;

  logic [W-1:0] cnt_q, cnt_d;
  logic [1:0]   quad_q, quad_d;
  logic [W:0]   sum;

  // Next count/quad: a write takes priority over a drain step on the same cycle
  always_comb begin
    sum    = {cnt_q[W-1], cnt_q} + {{(W-7){delta[7]}}, delta};
    cnt_d  = cnt_q;
    quad_d = quad_q;
    if (wr) begin
      // One extra bit of headroom: sign mismatch in the top two bits is overflow
      if (sum[W] != sum[W-1]) begin
        cnt_d = sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
        cnt_d = sum[W-1:0];
      end
    end else if (tick && (cnt_q != '0)) begin
      if (cnt_q[W-1]) begin
        cnt_d  = cnt_q + W'(1);
        quad_d = {~quad_q[0], quad_q[1]};
      end else begin
        cnt_d  = cnt_q - W'(1);
        quad_d = {quad_q[0], ~quad_q[1]};
      end
    end
  end

  // Axis state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      quad_q <= 2'b00;
    end else begin
      cnt_q  <= cnt_d;
      quad_q <= quad_d;
    end
  end

  assign cnt  = cnt_q;
  assign quad = quad_q;

endmodule

`default_nettype wire

// File: rtl/hid_multi.sv
//------------------------------------------------------------------------------
// Module   : hid_multi
// Purpose  : MCU command-frame decoder driving keyboard matrix, joystick bank
//            and a two-axis quadrature mouse with a free-running drain divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hid_multi #(
  parameter int NUM_JOY     = 2,
  parameter int MOUSE_CNT_W = 8,
  parameter int MOUSE_DIV_W = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  hid_multi_if.slave             bus,
  output logic [8*NUM_JOY-1:0]   joystick,
  input  logic [7:0]             keyboard_matrix_out,
  output logic [7:0]             keyboard_matrix_in,
  output logic [1:0]             mouse_btns,
  output logic [MOUSE_CNT_W-1:0] mouse_x_cnt,
  output logic [MOUSE_CNT_W-1:0] mouse_y_cnt,
  output logic [3:0]             mouse_quad,
  output logic                   mouse_strobe
);

  import hid_pkg::*;

  localparam logic [7:0] NUM_JOY_B   = 8'(NUM_JOY);
  localparam logic [7:0] CNT_W_B     = 8'(MOUSE_CNT_W);
  localparam logic [7:0] STATUS_CAPS = {NUM_JOY_B[3:0], CNT_W_B[4:1]};

  logic [3:0]             state_q, state_d;
  logic [7:0]             command_q, command_d;
  logic [7:0]             joy_dev_q, joy_dev_d;
  logic [7:0]             data_out_q, data_out_d;
  logic [1:0]             btns_q, btns_d;
  logic [7:0]             key_q [8];
  logic [7:0]             key_d [8];
  logic [8*NUM_JOY-1:0]   joy_q, joy_d;
  logic                   strobe_q, strobe_d;
  logic                   wr_x, wr_y;
  logic [MOUSE_DIV_W-1:0] div_q;
  logic                   tick;
  logic [1:0]             quad_x, quad_y;

  // Frame parser: a start byte always restarts the frame, data bytes act on the current index
  always_comb begin
    state_d    = state_q;
    command_d  = command_q;
    joy_dev_d  = joy_dev_q;
    data_out_d = data_out_q;
    btns_d     = btns_q;
    key_d      = key_q;
    joy_d      = joy_q;
    strobe_d   = 1'b0;
    wr_x       = 1'b0;
    wr_y       = 1'b0;
    if (bus.data_in_strobe) begin
      if (bus.data_in_start) begin
        command_d = bus.data_in;
        state_d   = 4'd1;
        joy_dev_d = 8'd0;
        if (bus.data_in == CMD_KBCLR) begin
          for (int r = 0; r < 8; r++) key_d[r] = 8'hFF;
        end
      end else if (state_q != 4'd0) begin
        if (state_q != 4'd15) state_d = state_q + 4'd1;
        case (command_q)
          CMD_STATUS: begin
            case (state_q)
              4'd1:    data_out_d = STATUS_ID0;
              4'd2:    data_out_d = STATUS_ID1;
              4'd3:    data_out_d = STATUS_CAPS;
              default: ;
            endcase
          end
          CMD_KEY: begin
            if (state_q == 4'd1) key_d[bus.data_in[2:0]][bus.data_in[5:3]] = bus.data_in[7];
          end
          CMD_MOUSE: begin
            case (state_q)
              4'd1: btns_d = bus.data_in[1:0];
              4'd2: wr_x = 1'b1;
              4'd3: begin
                wr_y     = 1'b1;
                strobe_d = 1'b1;
              end
              default: ;
            endcase
          end
          CMD_JOY: begin
            if (state_q == 4'd1) begin
              joy_dev_d = bus.data_in;
            end else if (state_q == 4'd2) begin
              // Out-of-range device numbers match no slot and are dropped
              for (int n = 0; n < NUM_JOY; n++) begin
                if (joy_dev_q == 8'(n)) joy_d[8*n +: 8] = bus.data_in;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Parser, keyboard, joystick and reply registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= 4'd0;
      command_q  <= 8'd0;
      joy_dev_q  <= 8'd0;
      data_out_q <= 8'd0;
      btns_q     <= 2'b00;
      joy_q      <= '0;
      strobe_q   <= 1'b0;
      for (int r = 0; r < 8; r++) key_q[r] <= 8'hFF;
    end else begin
      state_q    <= state_d;
      command_q  <= command_d;
      joy_dev_q  <= joy_dev_d;
      data_out_q <= data_out_d;
      btns_q     <= btns_d;
      joy_q      <= joy_d;
      strobe_q   <= strobe_d;
      key_q      <= key_d;
    end
  end

  // Free-running drain divider; tick whenever it wraps through zero
  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_q + MOUSE_DIV_W'(1);
  end

  assign tick = (div_q == '0);

  // Row sense: AND of every key row whose column is driven low
  always_comb begin
    keyboard_matrix_in = 8'hFF;
    for (int r = 0; r < 8; r++) begin
      if (!keyboard_matrix_out[r]) keyboard_matrix_in = keyboard_matrix_in & key_q[r];
    end
  end

  hid_mouse_axis #(.MOUSE_CNT_W(MOUSE_CNT_W)) u_axis_x (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .wr    (wr_x),
    .delta (bus.data_in),
    .cnt   (mouse_x_cnt),
    .quad  (quad_x)
  );

  hid_mouse_axis #(.MOUSE_CNT_W(MOUSE_CNT_W)) u_axis_y (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .wr    (wr_y),
    .delta (bus.data_in),
    .cnt   (mouse_y_cnt),
    .quad  (quad_y)
  );

  assign bus.data_out  = data_out_q;
  assign joystick      = joy_q;
  assign mouse_btns    = btns_q;
  assign mouse_strobe  = strobe_q;
  assign mouse_quad    = {quad_x, quad_y};

endmodule

`default_nettype wire
